// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: an in-order circular buffer of DEPTH entries
// carrying an opaque payload, with back-pressure, synchronous flush and bubble zeroing.
module pipe_stage_elastic #(
  parameter int WIDTH       = 224,
  parameter int DEPTH       = 2,
  parameter bit BUBBLE_ZERO = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  // Handshake: a beat moves on a port in any cycle where valid and ready are
  // both high at the rising edge; valid never waits for ready, and a flush in
  // that cycle cancels both the push and the pop.

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;

  // Explicit wrap so non-power-of-two depths stay within the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign head      = mem[rd_ptr];

  generate
    if (DEPTH == 1) begin : g_single
      // Single register: refill in the same cycle the held beat leaves.
      assign in_ready = !out_valid | out_ready;
    end else begin : g_multi
      // Purely registered ready; no path from out_ready.
      assign in_ready = (count_q < FULL);
    end
  endgenerate

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  generate
    if (BUBBLE_ZERO) begin : g_bubble_zero
      assign out_data = out_valid ? head : '0;
    end else begin : g_bubble_hold
      assign out_data = head;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: DEPTH=2, DEPTH=1 and DEPTH=3 instances checked
// every cycle against a queue-based reference model.
module tb_pipe_stage_elastic;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [W-1:0] in_data_a, out_data_a;
  logic [1:0]   count_a;
  logic         flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [W-1:0] in_data_b, out_data_b;
  logic [0:0]   count_b;
  logic         flush_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [W-1:0] in_data_c, out_data_c;
  logic [1:0]   count_c;

  pipe_stage_elastic #(.WIDTH(W), .DEPTH(2), .BUBBLE_ZERO(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .count(count_a));

  pipe_stage_elastic #(.WIDTH(W), .DEPTH(1), .BUBBLE_ZERO(1'b1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .count(count_b));

  pipe_stage_elastic #(.WIDTH(W), .DEPTH(3), .BUBBLE_ZERO(1'b1)) dut_c (
    .clk(clk), .reset(reset), .flush(flush_c),
    .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
    .count(count_c));

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  logic [W-1:0] exp_q_c[$];
  int  checks = 0;
  int  errors = 0;
  int  n_out_a = 0, n_out_b = 0, n_out_c = 0;
  bit  acc_a, acc_b, acc_c;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs set; checks all outputs,
  // advances the model across the next rising edge, returns at the next falling edge.
  task automatic tick();
    bit ev, er, pu, po;
    #1;
    ev = exp_q_a.size() != 0;
    er = exp_q_a.size() < 2;
    check("a_in_ready", W'(in_ready_a), W'(er));
    check("a_out_valid", W'(out_valid_a), W'(ev));
    check("a_count", W'(count_a), W'(exp_q_a.size()));
    check("a_out_data", out_data_a, ev ? exp_q_a[0] : '0);
    po = ev && out_ready_a && !flush_a;
    pu = in_valid_a && er && !flush_a;
    if (flush_a) exp_q_a.delete();
    else begin
      if (po) begin void'(exp_q_a.pop_front()); n_out_a++; end
      if (pu) exp_q_a.push_back(in_data_a);
    end
    acc_a = pu;

    ev = exp_q_b.size() != 0;
    er = !ev || out_ready_b;
    check("b_in_ready", W'(in_ready_b), W'(er));
    check("b_out_valid", W'(out_valid_b), W'(ev));
    check("b_count", W'(count_b), W'(exp_q_b.size()));
    check("b_out_data", out_data_b, ev ? exp_q_b[0] : '0);
    po = ev && out_ready_b && !flush_b;
    pu = in_valid_b && er && !flush_b;
    if (flush_b) exp_q_b.delete();
    else begin
      if (po) begin void'(exp_q_b.pop_front()); n_out_b++; end
      if (pu) exp_q_b.push_back(in_data_b);
    end
    acc_b = pu;

    ev = exp_q_c.size() != 0;
    er = exp_q_c.size() < 3;
    check("c_in_ready", W'(in_ready_c), W'(er));
    check("c_out_valid", W'(out_valid_c), W'(ev));
    check("c_count", W'(count_c), W'(exp_q_c.size()));
    check("c_out_data", out_data_c, ev ? exp_q_c[0] : '0);
    po = ev && out_ready_c && !flush_c;
    pu = in_valid_c && er && !flush_c;
    if (flush_c) exp_q_c.delete();
    else begin
      if (po) begin void'(exp_q_c.pop_front()); n_out_c++; end
      if (pu) exp_q_c.push_back(in_data_c);
    end
    acc_c = pu;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, k;
    bit pat [12] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 0};

    reset = 1'b1;
    {flush_a, in_valid_a, out_ready_a} = '0; in_data_a = '0;
    {flush_b, in_valid_b, out_ready_b} = '0; in_data_b = '0;
    {flush_c, in_valid_c, out_ready_c} = '0; in_data_c = '0;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready_a", W'(in_ready_a), W'(1));
    check("rst_count_a", W'(count_a), W'(0));
    check("rst_out_data_a", out_data_a, '0);
    reset = 1'b0;
    idle(2);

    // Streaming through DEPTH=2
    n_out_a = 0;
    out_ready_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid_a = 1'b1; in_data_a = W'(i);
      tick();
    end
    in_valid_a = 1'b0;
    idle(3);
    check("a_stream_n", W'(n_out_a), W'(8));

    // Back-pressure: fill, offer 0xC while full, then drain
    n_out_a = 0;
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 'hA; tick();
    in_data_a = 'hB; tick();
    in_data_a = 'hC; idle(3);
    out_ready_a = 1'b1;
    acc_a = 1'b0; k = 0;
    while (!acc_a && k < 10) begin tick(); k++; end
    check("a_bp_c_accepted", W'(acc_a), W'(1));
    in_valid_a = 1'b0;
    idle(4);
    check("a_bp_n", W'(n_out_a), W'(3));

    // Flush with a simultaneous push and pop
    n_out_a = 0;
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 'h11; tick();
    in_data_a = 'h22; tick();
    flush_a = 1'b1; in_data_a = 'h33; out_ready_a = 1'b1; tick();
    flush_a = 1'b0; in_valid_a = 1'b0;
    idle(3);
    check("a_flush_n", W'(n_out_a), W'(0));

    // Asynchronous reset in the middle of a cycle with two entries held
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; in_data_a = 'h44; tick();
    in_data_a = 'h55; tick();
    in_valid_a = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("arst_out_valid_a", W'(out_valid_a), W'(0));
    check("arst_out_data_a", out_data_a, '0);
    check("arst_count_a", W'(count_a), W'(0));
    check("arst_in_ready_a", W'(in_ready_a), W'(1));
    exp_q_a.delete(); exp_q_b.delete(); exp_q_c.delete();
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // DEPTH=1 with toggling out_ready and continuous input
    n_out_b = 0;
    d = 100;
    in_valid_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      out_ready_b = pat[i]; in_data_b = W'(d);
      tick();
      if (acc_b) d++;
    end
    in_valid_b = 1'b0; out_ready_b = 1'b1;
    idle(3);
    check("b_no_loss", W'(n_out_b), W'(d - 100));

    // DEPTH=3 wrap with random back-pressure
    n_out_c = 0;
    d = 0; k = 0;
    while (d < 10 && k < 200) begin
      in_valid_c = 1'b1; in_data_c = W'(d);
      out_ready_c = 1'($urandom_range(0, 1));
      tick();
      if (acc_c) d++;
      k++;
    end
    in_valid_c = 1'b0; out_ready_c = 1'b1;
    idle(5);
    check("c_wrap_pushed", W'(d), W'(10));
    check("c_wrap_n", W'(n_out_c), W'(10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
